// File: rtl/camera_frame_capture_pkg.sv
// Shared types and helpers for the camera capture path: Bayer phase codes,
// capture FSM encoding and the quad colour-position lookup.
package camera_pkg;

  localparam int OUT_WORD_W = 32;

  localparam logic [1:0] BAYER_GRBG = 2'd0;
  localparam logic [1:0] BAYER_RGGB = 2'd1;
  localparam logic [1:0] BAYER_BGGR = 2'd2;
  localparam logic [1:0] BAYER_GBRG = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_VSYNC,
    ST_CAPTURE,
    ST_DRAIN,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {CH_R, CH_G1, CH_G2, CH_B} chan_e;

  // Red sits at (rr,rc) inside the quad; blue is diagonal to it, greens fill the rest.
  function automatic chan_e color_sel(input logic [1:0] phase, input logic rp, input logic cp);
    logic rr, rc;
    case (phase)
      BAYER_GRBG: begin rr = 1'b0; rc = 1'b1; end
      BAYER_RGGB: begin rr = 1'b0; rc = 1'b0; end
      BAYER_BGGR: begin rr = 1'b1; rc = 1'b1; end
      default:    begin rr = 1'b1; rc = 1'b0; end
    endcase
    if (rp == rr && cp == rc)      return CH_R;
    else if (rp != rr && cp != rc) return CH_B;
    else if (!rp)                  return CH_G1;
    else                           return CH_G2;
  endfunction

endpackage

// File: rtl/camera_frame_capture_bayer_line_buffer.sv
// Simple dual-port line store holding the top row of each Bayer quad.
// Read data is registered and holds until the next read.
module bayer_line_buffer #(
  parameter int DEPTH = 320,
  parameter int WIDTH = 24,
  parameter int AW    = 9
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/camera_frame_capture.sv
// Crops a raw Bayer window, demosaics each 2x2 quad into one packed RGB word
// with its address, and accumulates saturating per-channel sums for AGC.
module camera_frame_capture
  import camera_pkg::*;
#(
  parameter int PIX_BITS    = 12,
  parameter int OUT_BITS    = 8,
  parameter int FRAME_W     = 320,
  parameter int FRAME_H     = 240,
  parameter int CNT_W       = 12,
  parameter int BAYER_PHASE = 0,
  parameter int SUM_W       = 26,
  parameter int ADDR_W      = 20
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  grab_start,
  input  logic                  grab_abort,
  input  logic [CNT_W-1:0]      x_start,
  input  logic [CNT_W-1:0]      y_start,
  input  logic [ADDR_W-1:0]     addr_base,
  input  logic                  href,
  input  logic                  vsync,
  input  logic                  pix_valid,
  input  logic [PIX_BITS-1:0]   pix_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_WORD_W-1:0] out_data,
  output logic [ADDR_W-1:0]     out_addr,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  frame_short,
  output logic [15:0]           overflow_count,
  output logic [SUM_W-1:0]      red_sum,
  output logic [SUM_W-1:0]      green_sum,
  output logic [SUM_W-1:0]      blue_sum
);

  localparam int              BUF_AW = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
  localparam logic [ADDR_W-1:0] LAST_Q = ADDR_W'(FRAME_W * FRAME_H - 1);
  localparam logic [CNT_W:0]  WIN_W  = (CNT_W+1)'(2 * FRAME_W);
  localparam logic [CNT_W:0]  WIN_H  = (CNT_W+1)'(2 * FRAME_H);
  localparam logic [1:0]      PHASE  = 2'(BAYER_PHASE);

  state_e                  state_q;
  logic [CNT_W-1:0]        col_q, row_q;
  logic                    href_q, vsync_q, line_pix_q;
  logic [PIX_BITS-1:0]     hold_q;
  logic [ADDR_W-1:0]       qidx_q, out_addr_q;
  logic                    out_valid_q, frame_done_q, frame_short_q;
  logic [OUT_WORD_W-1:0]   out_data_q;
  logic [15:0]             ovf_q;
  logic [SUM_W-1:0]        rsum_q, gsum_q, bsum_q;

  logic [CNT_W:0]          rel_c, rel_r;
  logic                    in_win, smp, rp, cp, buf_we, buf_re, quad_done;
  logic [BUF_AW-1:0]       buf_addr;
  logic [2*PIX_BITS-1:0]   buf_rdata;
  logic [3:0][PIX_BITS-1:0] quad_s;
  logic [PIX_BITS-1:0]     r_raw, b_raw;
  logic [PIX_BITS:0]       g_sum;
  logic [OUT_BITS-1:0]     r_ch, g_ch, b_ch;
  logic [OUT_WORD_W-1:0]   pix_word;
  logic                    vs_rise, vs_fall;

  function automatic logic [SUM_W-1:0] sat_add(input logic [SUM_W-1:0] acc,
                                               input logic [OUT_BITS-1:0] val);
    logic [SUM_W:0] s;
    s = {1'b0, acc} + (SUM_W+1)'(val);
    return s[SUM_W] ? '1 : s[SUM_W-1:0];
  endfunction

  assign vs_rise = vsync & ~vsync_q;
  assign vs_fall = ~vsync & vsync_q;

  // Raw sensor position tracking runs independently of the capture state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col_q      <= '0;
      row_q      <= '0;
      href_q     <= 1'b0;
      vsync_q    <= 1'b0;
      line_pix_q <= 1'b0;
      hold_q     <= '0;
    end else begin
      href_q  <= href;
      vsync_q <= vsync;
      if (!href)          col_q <= '0;
      else if (pix_valid) col_q <= col_q + CNT_W'(1);
      if (vs_rise)                         row_q <= '0;
      else if (href_q && !href && line_pix_q) row_q <= row_q + CNT_W'(1);
      if (href && pix_valid) line_pix_q <= 1'b1;
      else if (!href)        line_pix_q <= 1'b0;
      if (smp && !cp) hold_q <= pix_data;
    end
  end

  assign rel_c    = {1'b0, col_q} - {1'b0, x_start};
  assign rel_r    = {1'b0, row_q} - {1'b0, y_start};
  assign in_win   = (col_q >= x_start) && (rel_c < WIN_W) && (row_q >= y_start) && (rel_r < WIN_H);
  assign smp      = (state_q == ST_CAPTURE) && href && pix_valid && in_win;
  assign rp       = rel_r[0];
  assign cp       = rel_c[0];
  assign buf_addr = BUF_AW'(rel_c >> 1);
  assign buf_we   = smp && !rp && cp;
  // Read on the first bottom-row sample so the top pair is ready for the second.
  assign buf_re   = smp && rp && !cp;
  assign quad_done = smp && rp && cp;

  bayer_line_buffer #(
    .DEPTH (FRAME_W),
    .WIDTH (2 * PIX_BITS),
    .AW    (BUF_AW)
  ) u_line_buf (
    .clk     (clk),
    .we_i    (buf_we),
    .waddr_i (buf_addr),
    .wdata_i ({hold_q, pix_data}),
    .re_i    (buf_re),
    .raddr_i (buf_addr),
    .rdata_o (buf_rdata)
  );

  always_comb begin
    quad_s[0] = buf_rdata[2*PIX_BITS-1:PIX_BITS];
    quad_s[1] = buf_rdata[PIX_BITS-1:0];
    quad_s[2] = hold_q;
    quad_s[3] = pix_data;
    r_raw = '0;
    b_raw = '0;
    g_sum = '0;
    for (int i = 0; i < 4; i++) begin
      case (color_sel(PHASE, i[1], i[0]))
        CH_R:    r_raw = quad_s[i];
        CH_B:    b_raw = quad_s[i];
        default: g_sum = g_sum + {1'b0, quad_s[i]};
      endcase
    end
  end

  assign r_ch     = OUT_BITS'(r_raw >> (PIX_BITS - OUT_BITS));
  assign b_ch     = OUT_BITS'(b_raw >> (PIX_BITS - OUT_BITS));
  assign g_ch     = OUT_BITS'(g_sum >> (PIX_BITS + 1 - OUT_BITS));
  assign pix_word = {8'(b_ch), 8'h00, 8'(g_ch), 8'(r_ch)};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      qidx_q        <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_addr_q    <= '0;
      frame_done_q  <= 1'b0;
      frame_short_q <= 1'b0;
      ovf_q         <= '0;
      rsum_q        <= '0;
      gsum_q        <= '0;
      bsum_q        <= '0;
    end else begin
      frame_done_q <= 1'b0;
      if (grab_abort) begin
        state_q     <= ST_IDLE;
        out_valid_q <= 1'b0;
        rsum_q      <= '0;
        gsum_q      <= '0;
        bsum_q      <= '0;
      end else begin
        case (state_q)
          ST_IDLE: if (grab_start) begin
            state_q       <= ST_WAIT_VSYNC;
            qidx_q        <= '0;
            ovf_q         <= '0;
            frame_short_q <= 1'b0;
            rsum_q        <= '0;
            gsum_q        <= '0;
            bsum_q        <= '0;
          end
          ST_WAIT_VSYNC: if (vs_rise) state_q <= ST_CAPTURE;
          ST_CAPTURE: begin
            if (quad_done && qidx_q == LAST_Q) state_q <= ST_DRAIN;
            else if (vs_fall) begin
              frame_short_q <= 1'b1;
              state_q       <= ST_DRAIN;
            end
          end
          ST_DRAIN: if (!out_valid_q) begin
            state_q      <= ST_DONE;
            frame_done_q <= 1'b1;
          end
          default: state_q <= ST_IDLE;
        endcase

        if (out_valid_q && out_ready) out_valid_q <= 1'b0;
        // Dropped quads still advance the index so later addresses stay geometric.
        if (quad_done) begin
          qidx_q <= qidx_q + ADDR_W'(1);
          rsum_q <= sat_add(rsum_q, r_ch);
          gsum_q <= sat_add(gsum_q, g_ch);
          bsum_q <= sat_add(bsum_q, b_ch);
          if (out_valid_q && !out_ready) begin
            if (ovf_q != 16'hFFFF) ovf_q <= ovf_q + 16'd1;
          end else begin
            out_valid_q <= 1'b1;
            out_data_q  <= pix_word;
            out_addr_q  <= addr_base + qidx_q;
          end
        end
      end
    end
  end

  assign out_valid      = out_valid_q;
  assign out_data       = out_data_q;
  assign out_addr       = out_addr_q;
  assign busy           = (state_q != ST_IDLE);
  assign frame_done     = frame_done_q;
  assign frame_short    = frame_short_q;
  assign overflow_count = ovf_q;
  assign red_sum        = rsum_q;
  assign green_sum      = gsum_q;
  assign blue_sum       = bsum_q;

endmodule

// File: tb/tb_camera_frame_capture.sv
// Directed + randomized bench for camera_frame_capture on a 4x2 GRBG window
// with a narrow sum width so saturation is reachable.
module tb_camera_frame_capture;

  localparam int PB = 12, OB = 8, FW = 4, FH = 2, CW = 12, SW = 10, AW = 20;
  localparam int NQ = FW * FH;
  localparam int SMAX = (1 << SW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n, grab_start, grab_abort, href, vsync, pix_valid, out_ready;
  logic [CW-1:0] x_start, y_start;
  logic [AW-1:0] addr_base;
  logic [PB-1:0] pix_data;
  logic          out_valid, busy, frame_done, frame_short;
  logic [31:0]   out_data;
  logic [AW-1:0] out_addr;
  logic [15:0]   overflow_count;
  logic [SW-1:0] red_sum, green_sum, blue_sum;

  camera_frame_capture #(
    .PIX_BITS(PB), .OUT_BITS(OB), .FRAME_W(FW), .FRAME_H(FH), .CNT_W(CW),
    .BAYER_PHASE(0), .SUM_W(SW), .ADDR_W(AW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .grab_start(grab_start), .grab_abort(grab_abort),
    .x_start(x_start), .y_start(y_start), .addr_base(addr_base),
    .href(href), .vsync(vsync), .pix_valid(pix_valid), .pix_data(pix_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr),
    .busy(busy), .frame_done(frame_done), .frame_short(frame_short),
    .overflow_count(overflow_count),
    .red_sum(red_sum), .green_sum(green_sum), .blue_sum(blue_sum)
  );

  int          n_cmp = 0, n_err = 0;
  logic [11:0] img [8][12];
  logic [31:0] exp_w [NQ];
  int          exp_rs, exp_gs, exp_bs;
  logic [31:0] got_d [$];
  logic [AW-1:0] got_a [$];
  int          done_cnt;
  bit          rand_ready = 1'b0;

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      got_d.push_back(out_data);
      got_a.push_back(out_addr);
    end
    if (frame_done) done_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic grab;
    grab_start = 1'b1;
    tick();
    grab_start = 1'b0;
  endtask

  task automatic clear_mon;
    got_d.delete();
    got_a.delete();
    done_cnt = 0;
  endtask

  task automatic fill_ramp;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 12; c++) img[r][c] = 12'((16 * r + c) << 4);
  endtask

  task automatic fill_const(input logic [11:0] v);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 12; c++) img[r][c] = v;
  endtask

  task automatic fill_rand;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 12; c++) img[r][c] = 12'($urandom_range(0, 4095));
  endtask

  // GRBG quad: G1 top-left, R top-right, B bottom-left, G2 bottom-right.
  task automatic model(input int x0, input int y0, input int nq);
    int r, g1, g2, b, ga, rs, gs, bs, q;
    rs = 0; gs = 0; bs = 0;
    for (int qy = 0; qy < FH; qy++)
      for (int qx = 0; qx < FW; qx++) begin
        q  = qy * FW + qx;
        g1 = int'(img[y0 + 2*qy][x0 + 2*qx]);
        r  = int'(img[y0 + 2*qy][x0 + 2*qx + 1]);
        b  = int'(img[y0 + 2*qy + 1][x0 + 2*qx]);
        g2 = int'(img[y0 + 2*qy + 1][x0 + 2*qx + 1]);
        ga = (g1 + g2) / 2;
        exp_w[q] = {8'(b >> 4), 8'h00, 8'(ga >> 4), 8'(r >> 4)};
        if (q < nq) begin
          rs += r >> 4;
          gs += ga >> 4;
          bs += b >> 4;
        end
      end
    exp_rs = (rs > SMAX) ? SMAX : rs;
    exp_gs = (gs > SMAX) ? SMAX : gs;
    exp_bs = (bs > SMAX) ? SMAX : bs;
  endtask

  task automatic run_frame(input int nc, input int rows, input bit fall, input bit gaps);
    vsync = 1'b1;
    tick(); tick();
    for (int r = 0; r < rows; r++) begin
      href = 1'b1;
      for (int c = 0; c < nc; c++) begin
        if (gaps) begin
          pix_valid = 1'b0;
          repeat ($urandom_range(0, 2)) tick();
        end
        pix_valid = 1'b1;
        pix_data  = img[r][c];
        tick();
      end
      pix_valid = 1'b0;
      href      = 1'b0;
      tick(); tick();
    end
    if (fall) begin
      vsync = 1'b0;
      tick(); tick();
    end
  endtask

  task automatic wait_idle;
    int n;
    n = 0;
    while (busy && n < 500) begin
      tick();
      n++;
    end
    check("idle_timeout", 64'(busy), 64'd0);
    tick();
  endtask

  task automatic check_frame(input logic [AW-1:0] base, input int nq, input bit short_exp,
                             input bit all_acc);
    int idx;
    if (all_acc) begin
      check("nwords", 64'(got_d.size()), 64'(nq));
      check("overflow_zero", 64'(overflow_count), 64'd0);
    end else begin
      check("acc_plus_drop", 64'(got_d.size() + int'(overflow_count)), 64'(nq));
    end
    for (int i = 0; i < got_d.size(); i++) begin
      idx = int'(got_a[i] - base);
      if (all_acc) check("addr_seq", 64'(got_a[i]), 64'(base + AW'(i)));
      check("addr_in_range", 64'(idx < nq), 64'd1);
      if (idx < nq) check("data", 64'(got_d[i]), 64'(exp_w[idx]));
    end
    check("frame_done_cnt", 64'(done_cnt), 64'd1);
    check("frame_short", 64'(frame_short), 64'(short_exp));
    check("red_sum", 64'(red_sum), 64'(exp_rs));
    check("green_sum", 64'(green_sum), 64'(exp_gs));
    check("blue_sum", 64'(blue_sum), 64'(exp_bs));
  endtask

  initial begin
    logic [31:0] w0;
    int x0, y0;
    reset_n = 1'b0; grab_start = 1'b0; grab_abort = 1'b0;
    href = 1'b0; vsync = 1'b0; pix_valid = 1'b0; pix_data = '0;
    out_ready = 1'b1; x_start = '0; y_start = '0; addr_base = '0;
    done_cnt = 0;
    repeat (3) tick();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_frame_done", 64'(frame_done), 64'd0);
    check("rst_frame_short", 64'(frame_short), 64'd0);
    check("rst_overflow", 64'(overflow_count), 64'd0);
    check("rst_sums", 64'({red_sum, green_sum, blue_sum}), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_addr", 64'(out_addr), 64'd0);
    reset_n = 1'b1;
    tick();

    // Ramp frame, window at origin.
    fill_ramp(); model(0, 0, NQ);
    addr_base = 20'h00100;
    clear_mon(); grab(); run_frame(8, 4, 1'b1, 1'b1); wait_idle();
    check_frame(20'h00100, NQ, 1'b0, 1'b1);
    w0 = (got_d.size() > 0) ? got_d[0] : 32'hxxxxxxxx;
    check("ramp_word0", 64'(w0), 64'h10000801);

    // Offset window inside a larger raw frame.
    x_start = 12'd2; y_start = 12'd2; model(2, 2, NQ);
    addr_base = 20'h003F0;
    clear_mon(); grab(); run_frame(12, 8, 1'b1, 1'b1); wait_idle();
    check_frame(20'h003F0, NQ, 1'b0, 1'b1);
    w0 = (got_d.size() > 0) ? got_d[0] : 32'hxxxxxxxx;
    check("offset_word0", 64'(w0), 64'h32002A23);

    // Full back-pressure: quad 0 holds, the rest are dropped.
    x_start = '0; y_start = '0; model(0, 0, NQ);
    addr_base = 20'h00200; out_ready = 1'b0;
    clear_mon(); grab(); run_frame(8, 4, 1'b1, 1'b0);
    tick(); tick();
    check("bp_valid", 64'(out_valid), 64'd1);
    check("bp_addr", 64'(out_addr), 64'h200);
    check("bp_data", 64'(out_data), 64'(exp_w[0]));
    check("bp_overflow", 64'(overflow_count), 64'd7);
    check("bp_no_done", 64'(done_cnt), 64'd0);
    out_ready = 1'b1;
    wait_idle();
    check("bp_done", 64'(done_cnt), 64'd1);
    check("bp_words", 64'(got_d.size()), 64'd1);
    clear_mon(); grab(); run_frame(8, 4, 1'b1, 1'b1); wait_idle();
    check_frame(20'h00200, NQ, 1'b0, 1'b1);

    // Short frame: vsync drops after the first window line pair.
    model(0, 0, 4);
    clear_mon(); grab(); run_frame(8, 2, 1'b1, 1'b1); wait_idle();
    check_frame(20'h00200, 4, 1'b1, 1'b1);

    // Saturated samples drive the narrow sums to all-ones.
    fill_const(12'hFFF); model(0, 0, NQ);
    clear_mon(); grab(); run_frame(8, 4, 1'b1, 1'b0); wait_idle();
    check_frame(20'h00200, NQ, 1'b0, 1'b1);
    check("sat_red", 64'(red_sum), 64'h3FF);
    w0 = (got_d.size() > 0) ? got_d[0] : 32'hxxxxxxxx;
    check("sat_word0", 64'(w0), 64'hFF00FFFF);

    // Random images, window positions and (on odd runs) random out_ready.
    for (int k = 0; k < 6; k++) begin
      fill_rand();
      x0 = 2 * $urandom_range(0, 2);
      y0 = 2 * $urandom_range(0, 2);
      x_start = 12'(x0); y_start = 12'(y0);
      addr_base = 20'($urandom_range(0, 20'hFFF00));
      model(x0, y0, NQ);
      rand_ready = (k % 2) == 1;
      clear_mon(); grab(); run_frame(12, 8, 1'b1, 1'b1); wait_idle();
      rand_ready = 1'b0; out_ready = 1'b1;
      check_frame(addr_base, NQ, 1'b0, (k % 2) == 0);
    end

    // Abort in the middle of capture.
    fill_ramp(); x_start = '0; y_start = '0;
    clear_mon(); grab(); run_frame(8, 2, 1'b0, 1'b1);
    check("abort_busy_before", 64'(busy), 64'd1);
    grab_abort = 1'b1; tick(); grab_abort = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_valid", 64'(out_valid), 64'd0);
    check("abort_sums", 64'({red_sum, green_sum, blue_sum}), 64'd0);
    vsync = 1'b0;
    repeat (4) tick();
    check("abort_no_done", 64'(done_cnt), 64'd0);

    // Asynchronous reset while stuck in drain.
    out_ready = 1'b0;
    clear_mon(); grab(); run_frame(8, 4, 1'b1, 1'b0);
    check("drain_busy", 64'(busy), 64'd1);
    check("drain_valid", 64'(out_valid), 64'd1);
    reset_n = 1'b0;
    #2;
    check("rst2_outputs", 64'({out_valid, busy, frame_done, frame_short}), 64'd0);
    check("rst2_data_addr", 64'({out_data, out_addr}), 64'd0);
    check("rst2_ovf_sums", 64'({overflow_count, red_sum, green_sum, blue_sum}), 64'd0);
    check("rst2_no_done", 64'(done_cnt), 64'd0);
    out_ready = 1'b1;
    tick();
    reset_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
